// File: rtl/bus_interconnect_pkg.sv
// Shared definitions for the native-bus interconnect: FSM state encoding,
// error-cause codes, default error read data and the index-width helper.
package bus_interconnect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_ERR    = 2'd3
  } bus_state_e;

  localparam logic ERR_CAUSE_UNMAPPED = 1'b0;
  localparam logic ERR_CAUSE_TIMEOUT  = 1'b1;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // A single-slave map still needs a 1-bit index so that ports stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational priority address decoder.
// Ports:
//   addr - byte address to decode
//   hit  - address falls inside at least one window
//   idx  - index of the lowest-numbered matching window (0 when no hit)
// Window i matches when (addr & mask_i) == base_i. Lower indices win on
// overlap so a boot ROM can shadow the bottom of a larger flash window.
module bus_addr_decode
  import bus_interconnect_pkg::*;
#(
  parameter int                          NUM_SLAVES = 8,
  parameter logic [32*NUM_SLAVES-1:0]    SLAVE_BASE = '0,
  parameter logic [32*NUM_SLAVES-1:0]    SLAVE_MASK = '0,
  parameter int                          IDX_W      = idx_width(NUM_SLAVES)
) (
  input  logic [31:0]      addr,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  // Walk from the highest index down so the lowest match is written last.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/bus_interconnect.sv
// picorv32 native-bus interconnect: decodes the cpu address onto one-hot
// slave selects, registers the selected slave's read data and terminates
// unmapped or hung accesses with a bus error plus a sticky error log.
// Ports:
//   clk, reset_n          - system clock, async active-low reset
//   mem_valid/addr/wstrb  - cpu request (wstrb only matters to the slaves)
//   mem_ready, mem_rdata  - one-cycle response pulse and registered data
//   slv_select            - one-hot select, high through the whole access
//   slv_ready, slv_data_o - per-slave ready and flattened read data
//   err_clear             - clears the error log
//   bus_err_irq           - sticky error flag
//   err_addr, err_cause   - first uncleared error (cause 0 unmapped, 1 timeout)
//
// state  | meaning
// IDLE   | waiting for mem_valid, decode in progress
// ACCESS | slave selected, waiting for its ready or the timeout
// RESP   | mem_ready pulse carrying captured slave data
// ERR    | mem_ready pulse carrying ERR_DATA
module bus_interconnect
  import bus_interconnect_pkg::*;
#(
  parameter int                       NUM_SLAVES     = 8,
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_BASE     = '0,
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_MASK     = '0,
  parameter int                       TIMEOUT_CYCLES = 255,
  parameter logic [31:0]              ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       mem_valid,
  input  logic [31:0]                mem_addr,
  input  logic [3:0]                 mem_wstrb,
  output logic                       mem_ready,
  output logic [31:0]                mem_rdata,
  output logic [NUM_SLAVES-1:0]      slv_select,
  input  logic [NUM_SLAVES-1:0]      slv_ready,
  input  logic [32*NUM_SLAVES-1:0]   slv_data_o,
  input  logic                       err_clear,
  output logic                       bus_err_irq,
  output logic [31:0]                err_addr,
  output logic                       err_cause
);

  localparam int IDX_W = idx_width(NUM_SLAVES);
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  bus_state_e       state, state_next;
  logic [IDX_W-1:0] idx;
  logic [TW-1:0]    timer;

  logic             dec_hit;
  logic [IDX_W-1:0] dec_idx;

  logic             accept;
  logic             take_rdata;
  logic             err_enter;
  logic             cause_next;

  // Writes are never acknowledged with data here, so the strobes only reach
  // the slaves directly from the cpu bus.
  logic unused_wstrb;
  assign unused_wstrb = ^mem_wstrb;

  bus_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK),
    .IDX_W      (IDX_W)
  ) u_decode (
    .addr (mem_addr),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Abort takes precedence in ACCESS, then ready, then timeout, so a slave
  // answering on the last allowed cycle still completes normally.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    take_rdata = 1'b0;
    err_enter  = 1'b0;
    cause_next = ERR_CAUSE_UNMAPPED;
    case (state)
      ST_IDLE: begin
        if (mem_valid) begin
          if (dec_hit) begin
            state_next = ST_ACCESS;
            accept     = 1'b1;
          end else begin
            state_next = ST_ERR;
            err_enter  = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        if (!mem_valid) begin
          state_next = ST_IDLE;
        end else if (slv_ready[idx]) begin
          state_next = ST_RESP;
          take_rdata = 1'b1;
        end else if (timer == TIMER_LAST) begin
          state_next = ST_ERR;
          err_enter  = 1'b1;
          cause_next = ERR_CAUSE_TIMEOUT;
        end
      end
      ST_RESP:  state_next = ST_IDLE;
      ST_ERR:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    slv_select = '0;
    if (state == ST_ACCESS) slv_select[idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx         <= '0;
      timer       <= '0;
      mem_ready   <= 1'b0;
      mem_rdata   <= '0;
      bus_err_irq <= 1'b0;
      err_addr    <= '0;
      err_cause   <= 1'b0;
    end else begin
      mem_ready <= take_rdata | err_enter;

      if (accept) begin
        idx   <= dec_idx;
        timer <= '0;
      end else if (state == ST_ACCESS) begin
        timer <= timer + 1'b1;
      end

      if (take_rdata)     mem_rdata <= slv_data_o[32*idx +: 32];
      else if (err_enter) mem_rdata <= ERR_DATA;

      // A clear coinciding with a new error leaves the new error logged.
      if (err_enter && (err_clear || !bus_err_irq)) begin
        bus_err_irq <= 1'b1;
        err_addr    <= mem_addr;
        err_cause   <= cause_next;
      end else if (err_clear) begin
        bus_err_irq <= 1'b0;
        err_addr    <= '0;
        err_cause   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bus_interconnect.sv
module tb_bus_interconnect;

  localparam int NS = 3;
  localparam logic [32*NS-1:0] BASE = {32'h0002_0000, 32'h0000_0000, 32'h0000_0000};
  localparam logic [32*NS-1:0] MASK = {32'hFFFF_E000, 32'hFFFE_0000, 32'hFFFF_FFF0};
  localparam logic [31:0] D0 = 32'h1122_3344;
  localparam logic [31:0] D1 = 32'h5566_7788;
  localparam logic [31:0] D2 = 32'h99AA_BBCC;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          mem_valid;
  logic [31:0]   mem_addr;
  logic [3:0]    mem_wstrb;
  logic [NS-1:0] slv_ready;
  logic [32*NS-1:0] slv_data_o;
  logic          err_clear;

  // main instance, long timeout
  logic          mem_ready;
  logic [31:0]   mem_rdata;
  logic [NS-1:0] slv_select;
  logic          bus_err_irq;
  logic [31:0]   err_addr;
  logic          err_cause;

  // short-timeout instance sharing the same inputs
  logic          t_mem_ready;
  logic [31:0]   t_mem_rdata;
  logic [NS-1:0] t_slv_select;
  logic          t_bus_err_irq;
  logic [31:0]   t_err_addr;
  logic          t_err_cause;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bus_interconnect #(
    .NUM_SLAVES(NS), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK),
    .TIMEOUT_CYCLES(16), .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .slv_select(slv_select), .slv_ready(slv_ready), .slv_data_o(slv_data_o),
    .err_clear(err_clear), .bus_err_irq(bus_err_irq), .err_addr(err_addr),
    .err_cause(err_cause)
  );

  bus_interconnect #(
    .NUM_SLAVES(NS), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK),
    .TIMEOUT_CYCLES(4), .ERR_DATA(32'hDEAD_BEEF)
  ) dut_to (
    .clk(clk), .reset_n(reset_n), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_ready(t_mem_ready), .mem_rdata(t_mem_rdata),
    .slv_select(t_slv_select), .slv_ready(slv_ready), .slv_data_o(slv_data_o),
    .err_clear(err_clear), .bus_err_irq(t_bus_err_irq), .err_addr(t_err_addr),
    .err_cause(t_err_cause)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wstrb = '0;
    slv_ready = '0;
    err_clear = 1'b0;
  endtask

  task automatic test_reset();
    idle_bus();
    slv_data_o = {D2, D1, D0};
    reset_n = 1'b0;
    tick();
    tick();
    total++;
    if ({mem_ready, mem_rdata, slv_select, bus_err_irq, err_addr, err_cause} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got ready=%b rdata=%h sel=%b irq=%b eaddr=%h cause=%b, want all zero",
               mem_ready, mem_rdata, slv_select, bus_err_irq, err_addr, err_cause);
    end
    reset_n = 1'b1;
    tick();
  endtask

  // 0x4 hits s0 and s1; s0 must win and answer at cycle 3
  task automatic test_read_s0();
    mem_valid = 1'b1; mem_addr = 32'h4; slv_ready = 3'b011;
    total++;
    if (mem_ready !== 1'b0 || slv_select !== 3'b000) begin
      bad++; $display("FAIL s0_cycle1: ready=%b sel=%b want 0/000", mem_ready, slv_select);
    end
    tick();
    total++;
    if (mem_ready !== 1'b0 || slv_select !== 3'b001) begin
      bad++; $display("FAIL s0_cycle2: ready=%b sel=%b want 0/001", mem_ready, slv_select);
    end
    tick();
    total++;
    if (mem_ready !== 1'b1 || mem_rdata !== D0 || slv_select !== 3'b000) begin
      bad++; $display("FAIL s0_cycle3: ready=%b rdata=%h sel=%b want 1/%h/000", mem_ready, mem_rdata, slv_select, D0);
    end
    idle_bus();
    tick();
    total++;
    if (mem_ready !== 1'b0) begin
      bad++; $display("FAIL s0_pulse: ready=%b want 0", mem_ready);
    end
  endtask

  // s1 ready only on its 5th access cycle; other slaves' ready is ignored
  task automatic test_read_s1_wait();
    mem_valid = 1'b1; mem_addr = 32'h1000; slv_ready = 3'b101;
    tick();
    for (int k = 1; k <= 5; k++) begin
      total++;
      if (slv_select !== 3'b010 || mem_ready !== 1'b0) begin
        bad++; $display("FAIL s1_wait_%0d: sel=%b ready=%b want 010/0", k, slv_select, mem_ready);
      end
      if (k == 5) slv_ready = 3'b010;
      tick();
    end
    total++;
    if (mem_ready !== 1'b1 || mem_rdata !== D1 || slv_select !== 3'b000) begin
      bad++; $display("FAIL s1_resp: ready=%b rdata=%h sel=%b want 1/%h/000", mem_ready, mem_rdata, slv_select, D1);
    end
    idle_bus();
    tick();
    total++;
    if (mem_ready !== 1'b0) begin
      bad++; $display("FAIL s1_pulse: ready=%b want 0", mem_ready);
    end
  endtask

  task automatic test_abort();
    mem_valid = 1'b1; mem_addr = 32'h0002_0010;
    tick();
    total++;
    if (slv_select !== 3'b100) begin
      bad++; $display("FAIL abort_sel: sel=%b want 100", slv_select);
    end
    idle_bus();
    tick();
    total++;
    if (slv_select !== 3'b000 || mem_ready !== 1'b0) begin
      bad++; $display("FAIL abort_clear: sel=%b ready=%b want 000/0", slv_select, mem_ready);
    end
    tick();
    total++;
    if (mem_ready !== 1'b0 || bus_err_irq !== 1'b0) begin
      bad++; $display("FAIL abort_quiet: ready=%b irq=%b want 0/0", mem_ready, bus_err_irq);
    end
  endtask

  task automatic test_unmapped();
    mem_valid = 1'b1; mem_addr = 32'h9000_0000; mem_wstrb = 4'hF;
    tick();
    total++;
    if (mem_ready !== 1'b1 || mem_rdata !== 32'hDEAD_BEEF || slv_select !== 3'b000) begin
      bad++; $display("FAIL unmapped_resp: ready=%b rdata=%h sel=%b want 1/deadbeef/000", mem_ready, mem_rdata, slv_select);
    end
    total++;
    if (bus_err_irq !== 1'b1 || err_addr !== 32'h9000_0000 || err_cause !== 1'b0) begin
      bad++; $display("FAIL unmapped_log: irq=%b eaddr=%h cause=%b want 1/90000000/0", bus_err_irq, err_addr, err_cause);
    end
    idle_bus();
    tick();
    total++;
    if (mem_ready !== 1'b0) begin
      bad++; $display("FAIL unmapped_pulse: ready=%b want 0", mem_ready);
    end
  endtask

  // err_clear in the same cycle as a new error: the new error is logged
  task automatic test_clear_collision();
    mem_valid = 1'b1; mem_addr = 32'h9000_0010; err_clear = 1'b1;
    tick();
    total++;
    if (bus_err_irq !== 1'b1 || err_addr !== 32'h9000_0010 || err_cause !== 1'b0) begin
      bad++; $display("FAIL clear_collision: irq=%b eaddr=%h cause=%b want 1/90000010/0", bus_err_irq, err_addr, err_cause);
    end
    idle_bus();
    tick();
  endtask

  task automatic test_reset_mid_access();
    mem_valid = 1'b1; mem_addr = 32'h0002_0010;
    tick();
    total++;
    if (slv_select !== 3'b100) begin
      bad++; $display("FAIL mid_sel: sel=%b want 100", slv_select);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({mem_ready, mem_rdata, slv_select, bus_err_irq, err_addr, err_cause} !== '0) begin
      bad++; $display("FAIL mid_reset_async: ready=%b rdata=%h sel=%b irq=%b eaddr=%h cause=%b want all zero",
                      mem_ready, mem_rdata, slv_select, bus_err_irq, err_addr, err_cause);
    end
    idle_bus();
    #2 reset_n = 1'b1;
    tick();
    mem_valid = 1'b1; mem_addr = 32'h0002_0010; slv_ready = 3'b100;
    tick();
    tick();
    total++;
    if (mem_ready !== 1'b1 || mem_rdata !== D2) begin
      bad++; $display("FAIL post_reset_read: ready=%b rdata=%h want 1/%h", mem_ready, mem_rdata, D2);
    end
    idle_bus();
    tick();
  endtask

  task automatic test_timeout();
    mem_valid = 1'b1; mem_addr = 32'h0002_0000;
    tick();
    for (int k = 1; k <= 4; k++) begin
      total++;
      if (t_slv_select !== 3'b100 || t_mem_ready !== 1'b0) begin
        bad++; $display("FAIL to_wait_%0d: sel=%b ready=%b want 100/0", k, t_slv_select, t_mem_ready);
      end
      tick();
    end
    total++;
    if (t_mem_ready !== 1'b1 || t_mem_rdata !== 32'hDEAD_BEEF || t_slv_select !== 3'b000) begin
      bad++; $display("FAIL to_resp: ready=%b rdata=%h sel=%b want 1/deadbeef/000", t_mem_ready, t_mem_rdata, t_slv_select);
    end
    total++;
    if (t_bus_err_irq !== 1'b1 || t_err_addr !== 32'h0002_0000 || t_err_cause !== 1'b1) begin
      bad++; $display("FAIL to_log: irq=%b eaddr=%h cause=%b want 1/00020000/1", t_bus_err_irq, t_err_addr, t_err_cause);
    end
    idle_bus();
    tick();
    mem_valid = 1'b1; mem_addr = 32'h9000_0000;
    tick();
    total++;
    if (t_mem_ready !== 1'b1 || t_err_addr !== 32'h0002_0000 || t_err_cause !== 1'b1) begin
      bad++; $display("FAIL to_first_kept: ready=%b eaddr=%h cause=%b want 1/00020000/1", t_mem_ready, t_err_addr, t_err_cause);
    end
    idle_bus();
    tick();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    total++;
    if (t_bus_err_irq !== 1'b0 || t_err_addr !== 32'h0 || t_err_cause !== 1'b0) begin
      bad++; $display("FAIL to_clear: irq=%b eaddr=%h cause=%b want 0/0/0", t_bus_err_irq, t_err_addr, t_err_cause);
    end
  endtask

  // ready arrives on the final allowed cycle: response wins over timeout
  task automatic test_ready_at_timeout();
    mem_valid = 1'b1; mem_addr = 32'h0002_0004;
    tick();
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) slv_ready = 3'b100;
      tick();
    end
    total++;
    if (t_mem_ready !== 1'b1 || t_mem_rdata !== D2 || t_bus_err_irq !== 1'b0) begin
      bad++; $display("FAIL ready_vs_timeout: ready=%b rdata=%h irq=%b want 1/%h/0", t_mem_ready, t_mem_rdata, t_bus_err_irq, D2);
    end
    idle_bus();
    tick();
  endtask

  initial begin
    test_reset();
    test_read_s0();
    test_read_s1_wait();
    test_abort();
    test_unmapped();
    test_clear_collision();
    test_reset_mid_access();
    test_timeout();
    test_ready_at_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
